seg_scan_8: RTL

Time-multiplexed driver for an 8-position common-cathode/anode 7-segment display. Consumes the eight 4-bit digit codes produced by the digit-split stage (0–9 numerals, 10 = blank, 11 = dash) and drives segment and digit-select lines with a fixed per-digit dwell time. A blanking gap between digit switches suppresses ghosting. Inputs are snapshotted once per frame so a digit never tears mid-frame.

---
 rtl/seg_scan_8.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/seg_scan_8.sv
// -----------------------------------------------------------------------------
// seg_scan_8
//
// Time-multiplexed driver for an 8-position 7-segment display. Each position
// gets a slot of DWELL_CYC clocks. The first BLANK_CYC clocks of every slot
// drive all digits off, which suppresses ghosting when the select moves to the
// next position. The remaining clocks of the slot light one position.
//
// The eight digit codes and the decimal-point enables are copied into shadow
// registers once per frame, at the end of position 7's slot. They are also
// copied on the first clock edge after reset is released. A digit therefore
// never changes in the middle of a frame.
//
// Digit codes: 0-9 are numerals, 10 is blank, 11 is a dash, 12-15 are blank.
//
// Parameters
//   DWELL_CYC      clocks per digit slot (>= 2)
//   BLANK_CYC      all-off clocks at the start of each slot (0 .. DWELL_CYC-1)
//   SEG_ACTIVE_LOW 1: segment lines are active-low, 0: active-high
//   SEL_ACTIVE_LOW 1: select lines are active-low, 0: active-high
//
// Ports
//   sys_clk        system clock; all logic runs on the rising edge
//   sys_rst        asynchronous active-high reset
//   bit_7..bit_0   digit codes; bit_i is shown on position sel[i]
//   dp_en[7:0]     dp_en[i] lights the decimal point of position i
//   seg[7:0]       segment lines: seg[7] = dp, seg[6:0] = g,f,e,d,c,b,a
//   sel[7:0]       digit selects: one position active, or none
//   frame_start    one-clock pulse after each snapshot of the inputs
// -----------------------------------------------------------------------------
module seg_scan_8 #(
    parameter int unsigned DWELL_CYC      = 50000,
    parameter int unsigned BLANK_CYC      = 500,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [3:0] bit_7,
    input  logic [3:0] bit_6,
    input  logic [3:0] bit_5,
    input  logic [3:0] bit_4,
    input  logic [3:0] bit_3,
    input  logic [3:0] bit_2,
    input  logic [3:0] bit_1,
    input  logic [3:0] bit_0,
    input  logic [7:0] dp_en,
    output logic [7:0] seg,
    output logic [7:0] sel,
    output logic       frame_start
);

    localparam int unsigned    CNT_W     = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // XOR masks that turn the logical (active-high) levels into pin levels.
    localparam logic [7:0] SEG_INV = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [7:0] SEL_INV = SEL_ACTIVE_LOW ? 8'hFF : 8'h00;

    localparam logic [3:0] CODE_BLANK = 4'd10;

    // Active-high segment pattern {g,f,e,d,c,b,a} for one digit code.
    function automatic logic [6:0] decode_digit(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            4'd11:   pat = 7'h40;
            default: pat = 7'h00;   // 10 and 12-15 are blank
        endcase
        return pat;
    endfunction

    // State registers
    logic [CNT_W-1:0] cnt_q,          cnt_d;
    logic [2:0]       idx_q,          idx_d;
    logic [7:0][3:0]  shadow_q,       shadow_d;
    logic [7:0]       shadow_dp_q,    shadow_dp_d;
    logic             load_pending_q, load_pending_d;
    logic [7:0]       seg_q,          seg_d;
    logic [7:0]       sel_q,          sel_d;
    logic             frame_start_q,  frame_start_d;

    // Combinational helpers
    logic       cnt_wrap_s;
    logic       load_s;
    logic       blank_s;
    logic [7:0] seg_log_s;
    logic [7:0] sel_log_s;

    // Slot counter, digit index and frame snapshot.
    always_comb begin
        cnt_wrap_s = (cnt_q == CNT_LAST);

        if (cnt_wrap_s) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;      // 3-bit index wraps 7 -> 0 by itself
        end else begin
            cnt_d = cnt_q + CNT_ONE;
            idx_d = idx_q;
        end

        // New frame data is taken when position 7's slot ends, and once
        // right after reset so the first lit slot never shows reset blanks.
        load_s = load_pending_q || (cnt_wrap_s && (idx_q == 3'd7));

        if (load_s) begin
            shadow_d    = {bit_7, bit_6, bit_5, bit_4, bit_3, bit_2, bit_1, bit_0};
            shadow_dp_d = dp_en;
        end else begin
            shadow_d    = shadow_q;
            shadow_dp_d = shadow_dp_q;
        end

        load_pending_d = 1'b0;
        frame_start_d  = load_s;
    end

    // Output pattern for the current slot phase, then pin polarity.
    always_comb begin
        blank_s = (cnt_q < CNT_BLANK);

        if (blank_s) begin
            sel_log_s = 8'h00;
            seg_log_s = 8'h00;
        end else begin
            sel_log_s = 8'h01 << idx_q;
            seg_log_s = {shadow_dp_q[idx_q], decode_digit(shadow_q[idx_q])};
        end

        seg_d = seg_log_s ^ SEG_INV;
        sel_d = sel_log_s ^ SEL_INV;
    end

    // State and output registers; reset forces every line inactive at once.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_q          <= '0;
            idx_q          <= 3'd0;
            shadow_q       <= {8{CODE_BLANK}};
            shadow_dp_q    <= 8'h00;
            load_pending_q <= 1'b1;
            seg_q          <= SEG_INV;
            sel_q          <= SEL_INV;
            frame_start_q  <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            shadow_q       <= shadow_d;
            shadow_dp_q    <= shadow_dp_d;
            load_pending_q <= load_pending_d;
            seg_q          <= seg_d;
            sel_q          <= sel_d;
            frame_start_q  <= frame_start_d;
        end
    end

    assign seg         = seg_q;
    assign sel         = sel_q;
    assign frame_start = frame_start_q;

endmodule
